// File: rtl/lane_hit_detect.sv
// lane_hit_detect: collision monitor for the lane playfield.
// Samples the pixel under the frog in its current lane and, after a grace
// period and a run of consecutive overlaps, latches a crash. The crash is
// broadcast on every hit bit and held, with the crashing lane, until reset.
module lane_hit_detect #(
    parameter int LANES   = 8,
    parameter int WIDTH   = 16,
    parameter int GRACE   = 4,
    parameter int CONFIRM = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [$clog2(LANES):0]     frog_row,
    input  logic [$clog2(WIDTH)-1:0]   frog_col,
    input  logic [LANES*WIDTH-1:0]     lane_pixels,
    output logic [LANES-1:0]           hit,
    output logic [$clog2(LANES)-1:0]   hit_lane,
    output logic                       game_over
);

    localparam int ROW_W = $clog2(LANES) + 1;
    localparam int COL_W = $clog2(WIDTH);
    localparam int HL_W  = $clog2(LANES);
    localparam int GW    = (GRACE > 0) ? $clog2(GRACE + 1) : 1;
    localparam int CW    = $clog2(CONFIRM + 1);

    localparam logic [1:0] ST_GRACE   = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;
    localparam logic [1:0] ST_DEAD    = 2'd3;

    // With no grace period the monitor comes out of reset already armed.
    localparam logic [1:0]    RST_STATE = (GRACE > 0) ? ST_GRACE : ST_ARMED;
    localparam logic [GW-1:0] RST_GCNT  = GW'(GRACE);

    logic [1:0]         state_q, state_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic [CW-1:0]      ccnt_q, ccnt_d;
    logic [CW-1:0]      ccnt_inc_s;
    logic [ROW_W-1:0]   cap_q, cap_d;
    logic [HL_W-1:0]    hit_lane_q, hit_lane_d;
    logic [LANES-1:0]   hit_q, hit_d;
    logic               game_over_q, game_over_d;
    logic [WIDTH-1:0]   row_pix_s;
    logic               overlap_s;
    logic               dead_entry_s;

    // Select the frog's lane row and the pixel under the frog; safe rows read as empty.
    always_comb begin
        row_pix_s = {WIDTH{1'b0}};
        overlap_s = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (frog_row == ROW_W'(k)) begin
                row_pix_s = lane_pixels[k*WIDTH +: WIDTH];
            end else begin
                row_pix_s = row_pix_s;
            end
        end
        // Column 0 is the leftmost pixel, i.e. the MSB of the lane row.
        for (int c = 0; c < WIDTH; c++) begin
            if (frog_col == COL_W'(c)) begin
                overlap_s = row_pix_s[WIDTH-1-c];
            end else begin
                overlap_s = overlap_s;
            end
        end
    end

    // Next-state logic for the grace / armed / confirm / dead sequence.
    always_comb begin
        state_d      = state_q;
        gcnt_d       = gcnt_q;
        ccnt_d       = ccnt_q;
        cap_d        = cap_q;
        hit_lane_d   = hit_lane_q;
        hit_d        = hit_q;
        game_over_d  = game_over_q;
        dead_entry_s = 1'b0;
        ccnt_inc_s   = ccnt_q + CW'(1);
        if (enable) begin
            case (state_q)
                ST_GRACE: begin
                    // Overlaps are ignored here, even on the edge that arms.
                    if (gcnt_q > GW'(1)) begin
                        gcnt_d = gcnt_q - GW'(1);
                    end else begin
                        gcnt_d  = {GW{1'b0}};
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (overlap_s) begin
                        if (CONFIRM <= 1) begin
                            dead_entry_s = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM;
                            ccnt_d  = CW'(1);
                            cap_d   = frog_row;
                        end
                    end else begin
                        ccnt_d = {CW{1'b0}};
                    end
                end
                ST_CONFIRM: begin
                    if (overlap_s) begin
                        if (frog_row == cap_q) begin
                            if (ccnt_inc_s >= CW'(CONFIRM)) begin
                                dead_entry_s = 1'b1;
                            end else begin
                                ccnt_d = ccnt_inc_s;
                            end
                        end else begin
                            // A hit on a different lane starts a fresh run.
                            ccnt_d = CW'(1);
                            cap_d  = frog_row;
                        end
                    end else begin
                        state_d = ST_ARMED;
                        ccnt_d  = {CW{1'b0}};
                    end
                end
                ST_DEAD: begin
                    state_d = ST_DEAD;
                end
                default: begin
                    // Unreachable encoding: fail safe by freezing the lanes.
                    dead_entry_s = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        if (dead_entry_s) begin
            state_d     = ST_DEAD;
            ccnt_d      = CW'(CONFIRM);
            hit_lane_d  = frog_row[HL_W-1:0];
            hit_d       = {LANES{1'b1}};
            game_over_d = 1'b1;
        end else begin
            hit_d = hit_d;
        end
    end

    // State, counters and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RST_STATE;
            gcnt_q      <= RST_GCNT;
            ccnt_q      <= {CW{1'b0}};
            cap_q       <= {ROW_W{1'b0}};
            hit_lane_q  <= {HL_W{1'b0}};
            hit_q       <= {LANES{1'b0}};
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            ccnt_q      <= ccnt_d;
            cap_q       <= cap_d;
            hit_lane_q  <= hit_lane_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
        end
    end

    assign hit       = hit_q;
    assign hit_lane  = hit_lane_q;
    assign game_over = game_over_q;

endmodule

// File: doc/lane_hit_detect.md
# lane_hit_detect

Collision monitor for the lane playfield. It samples the 16-pixel row of every car lane at the frog's current cell and, once an overlap has persisted long enough, asserts `hit` back to all lane modules so they freeze in their crashed pattern. It also reports which lane caused the crash and raises `game_over`. It sits between the lane row generators and the frog/display logic; `hit` drives each lane module's `hit` input.

## Interface
- `LANES`, default 8: number of car lanes monitored.
- `WIDTH`, default 16: pixels per lane row.
- `GRACE`, default 4: enabled cycles after reset during which overlaps are ignored. 0 disables the grace period.
- `CONFIRM`, default 2: consecutive overlapping samples required to declare a crash. Minimum 1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  game running; when low, state and counters are frozen.
- `frog_row`  in  $clog2(LANES)+1  lane index of the frog; values >= LANES denote a safe row (no cars).
- `frog_col`  in  $clog2(WIDTH)  frog column; column c maps to pixel bit WIDTH-1-c.
- `lane_pixels`  in  LANES*WIDTH  flattened lane rows; lane k occupies bits [k*WIDTH +: WIDTH].
- `hit`  out  LANES  crash broadcast; all bits equal; drives each lane's `hit`.
- `hit_lane`  out  $clog2(LANES)  lane index of the crash; valid while `game_over`=1.
- `game_over`  out  1  high from the crash until reset.

## Operation
- `overlap` = (frog_row < LANES) && lane_pixels[frog_row*WIDTH + WIDTH-1-frog_col]. It is combinational and evaluated every cycle.
- States:
  - GRACE: `gcnt` counts down to zero; overlaps are ignored.
  - ARMED: no overlap pending.
  - CONFIRM: counting consecutive overlaps in `ccnt`.
  - DEAD: crash latched.
- Transitions are taken only on edges where enable=1. With enable=0, state, `gcnt`, `ccnt` and the outputs hold.
- GRACE transitions:
  - gcnt>1 → GRACE with gcnt-1.
  - gcnt==1 → ARMED.
- ARMED transitions:
  - overlap with CONFIRM==1 → DEAD.
  - overlap with CONFIRM>1 → CONFIRM with ccnt=1 and captured row = frog_row.
  - otherwise stay in ARMED.
- CONFIRM transitions:
  - overlap and frog_row == captured row: ccnt+1. Reaching CONFIRM → DEAD.
  - overlap on a different row: restart with ccnt=1 and captured row = frog_row.
  - no overlap → ARMED with ccnt=0.
- DEAD is terminal. Only `reset` leaves it. frog_row, frog_col and lane_pixels are ignored in DEAD.
- On entry to DEAD, `hit_lane` is loaded with the frog_row sampled at the transition edge.
- Outputs:
  - `hit` = all-ones in DEAD, else all-zeros.
  - `game_over` = (state==DEAD).
  - `hit_lane` is registered and holds after the crash.
- Counter widths are $clog2(GRACE+1) and $clog2(CONFIRM+1). Counters never wrap: ccnt saturates at CONFIRM and gcnt stops at 0.

## Timing
- Reset values:
  - state = GRACE with gcnt=GRACE. If GRACE==0, state = ARMED.
  - ccnt=0, hit=0, hit_lane=0, game_over=0.
- Reset asserted mid-operation, including in DEAD, returns everything to these values immediately (asynchronous).
- Grace length: the first GRACE enabled edges after reset release are spent in GRACE. The overlap sampled at edge GRACE+1 is the first one counted.
- Crash latency: if overlap is true at N consecutive enabled edges, `hit` and `game_over` are high after the CONFIRM-th of those edges. With CONFIRM=1 they rise on the same edge as the first overlap.
- An enable=0 gap inside a CONFIRM run freezes ccnt; it does not reset it.
- If overlap and the CONFIRM threshold coincide with the GRACE→ARMED edge, the overlap is ignored (GRACE has priority).
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Defaults (GRACE=4, CONFIRM=2); frog_row=2, frog_col=0; lane 2 = 16'b1000…0 from reset release → `hit` stays 0 for 4 edges. Overlap is counted from edge 5. `hit`=8'hFF, `game_over`=1 and `hit_lane`=2 after edge 6.
- Overlap for exactly one ARMED edge, then frog_col moves to a 0-pixel → no crash, ccnt returns to 0. A later 2-edge overlap crashes.
- frog_row=8 (safe) with every lane all-ones for 50 edges → `hit`=0 and `game_over`=0 throughout.
- Overlap run on row 3 with enable dropped for 5 cycles between samples 1 and 2 → crash on the second enabled overlap edge; `hit_lane`=3.
- Overlap on row 1 (1 edge), then on row 4 (2 edges) → crash with `hit_lane`=4.
- In DEAD, change all inputs for 20 cycles → outputs hold. Assert `reset` low asynchronously mid-cycle → `hit`=0 and `game_over`=0 immediately, and the 4-cycle grace period restarts.
